// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of async_fifo: one owner per grant,
// bounded bursts, stalls while the FIFO is full, and write/stall/overflow statistics.
module fifo_wr_arbiter #(
  parameter int unsigned data_width = 8,
  parameter int unsigned num_req    = 4,
  parameter int unsigned max_burst  = 4,
  parameter int unsigned src_w      = $clog2(num_req)
) (
  input  logic                          wr_clk_i,
  input  logic                          rst_i,
  input  logic [num_req-1:0]            req_i,
  input  logic [num_req*data_width-1:0] req_data_i,
  output logic [num_req-1:0]            gnt_o,
  input  logic                          full_i,
  input  logic                          overflow_i,
  output logic                          wr_en_o,
  output logic [data_width-1:0]         wdata_o,
  output logic [src_w-1:0]              wr_src_o,
  output logic                          busy_o,
  output logic [15:0]                   wr_count_o,
  output logic [15:0]                   stall_count_o,
  output logic                          ovf_err_o
);

  localparam int unsigned beat_w  = 4;
  localparam int unsigned cnt_w   = 16;
  localparam logic [beat_w-1:0]  last_beat = beat_w'(max_burst - 1);
  localparam logic [cnt_w-1:0]   cnt_max   = {cnt_w{1'b1}};
  localparam logic [num_req-1:0] gnt_one   = num_req'(1);

  typedef enum logic {
    st_idle  = 1'b0,
    st_burst = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [src_w-1:0]   owner_q, owner_d;
  logic [src_w-1:0]   rr_ptr_q, rr_ptr_d;
  logic [beat_w-1:0]  beat_cnt_q, beat_cnt_d;
  logic [cnt_w-1:0]   wr_count_q, wr_count_d;
  logic [cnt_w-1:0]   stall_count_q, stall_count_d;
  logic               ovf_err_q, ovf_err_d;

  logic               own_req_c;
  logic               wr_en_c;
  logic [src_w-1:0]   pick_c;
  logic [src_w-1:0]   cand_c;
  logic               found_c;

  // First requester at or after rr_ptr; index arithmetic wraps since num_req is a power of two
  always_comb begin
    pick_c  = rr_ptr_q;
    cand_c  = rr_ptr_q;
    found_c = 1'b0;
    for (int unsigned k = 0; k < num_req; k++) begin
      cand_c = rr_ptr_q + src_w'(k);
      if (!found_c && req_i[cand_c]) begin
        found_c = 1'b1;
        pick_c  = cand_c;
      end
    end
  end

  assign own_req_c = req_i[owner_q];
  assign wr_en_c   = (state_q == st_burst) && own_req_c && !full_i;

  // State register
  always_ff @(posedge wr_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= st_idle;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      wr_count_q    <= '0;
      stall_count_q <= '0;
      ovf_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      wr_count_q    <= wr_count_d;
      stall_count_q <= stall_count_d;
      ovf_err_q     <= ovf_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    wr_count_d    = wr_count_q;
    stall_count_d = stall_count_q;
    ovf_err_d     = ovf_err_q | overflow_i;

    case (state_q)
      st_idle: begin
        if (|req_i) begin
          owner_d    = pick_c;
          beat_cnt_d = '0;
          state_d    = st_burst;
        end
      end
      st_burst: begin
        if (!own_req_c) begin
          state_d  = st_idle;
          rr_ptr_d = owner_q + src_w'(1);
        end else if (full_i) begin
          if (stall_count_q != cnt_max) begin
            stall_count_d = stall_count_q + cnt_w'(1);
          end
        end else begin
          wr_count_d = wr_count_q + cnt_w'(1);
          beat_cnt_d = beat_cnt_q + beat_w'(1);
          if (beat_cnt_q == last_beat) begin
            state_d  = st_idle;
            rr_ptr_d = owner_q + src_w'(1);
          end
        end
      end
      default: state_d = st_idle;
    endcase
  end

  // FIFO-facing outputs follow the owner's request and full within the same cycle
  assign wr_en_o       = wr_en_c;
  assign gnt_o         = wr_en_c ? (gnt_one << owner_q) : '0;
  assign wdata_o       = req_data_i[owner_q*data_width +: data_width];
  assign wr_src_o      = owner_q;
  assign busy_o        = (state_q == st_burst);
  assign wr_count_o    = wr_count_q;
  assign stall_count_o = stall_count_q;
  assign ovf_err_o     = ovf_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all compared
// cycle by cycle against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            full;
  logic            overflow;
  logic            wr_en;
  logic [DW-1:0]   wdata;
  logic [1:0]      wr_src;
  logic            busy;
  logic [15:0]     wr_count;
  logic [15:0]     stall_count;
  logic            ovf_err;

  fifo_wr_arbiter #(.data_width(DW), .num_req(N), .max_burst(MB)) dut (
    .wr_clk_i     (clk),
    .rst_i        (rst),
    .req_i        (req),
    .req_data_i   (req_data),
    .gnt_o        (gnt),
    .full_i       (full),
    .overflow_i   (overflow),
    .wr_en_o      (wr_en),
    .wdata_o      (wdata),
    .wr_src_o     (wr_src),
    .busy_o       (busy),
    .wr_count_o   (wr_count),
    .stall_count_o(stall_count),
    .ovf_err_o    (ovf_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the port, how many beats it has written, counters
  bit           m_busy;
  int           m_owner, m_ptr, m_beats, m_wr, m_stall;
  bit           m_ovf;
  logic [N-1:0] m_gnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
    m_wr = 0; m_stall = 0; m_ovf = 0; m_gnt = '0;
  endtask

  task automatic compare_all();
    bit           e_wr;
    logic [N-1:0] one;
    logic [DW-1:0] e_data;
    one    = 1;
    e_wr   = m_busy && req[m_owner] && !full;
    m_gnt  = e_wr ? (one << m_owner) : '0;
    e_data = req_data[m_owner*DW +: DW];
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("wr_en", 32'(wr_en), 32'(e_wr));
    check_eq("gnt", 32'(gnt), 32'(m_gnt));
    check_eq("wdata", 32'(wdata), 32'(e_data));
    if (m_busy) check_eq("wr_src", 32'(wr_src), 32'(m_owner));
    check_eq("wr_count", 32'(wr_count), 32'(m_wr));
    check_eq("stall_count", 32'(stall_count), 32'(m_stall));
    check_eq("ovf_err", 32'(ovf_err), 32'(m_ovf));
  endtask

  task automatic model_step();
    bit found;
    if (overflow) m_ovf = 1;
    if (m_busy) begin
      if (!req[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end else if (full) begin
        if (m_stall < 65535) m_stall++;
      end else begin
        m_wr = (m_wr + 1) % 65536;
        m_beats++;
        if (m_beats == MB) begin
          m_busy = 0;
          m_ptr  = (m_owner + 1) % N;
        end
      end
    end else if (req != '0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found   = 1;
          m_owner = (m_ptr + k) % N;
        end
      end
      m_beats = 0;
      m_busy  = 1;
    end
  endtask

  // One clock: drive at negedge, compare, then advance the model at posedge
  task automatic cycle(input logic [N-1:0] r, input logic f, input logic o);
    @(negedge clk);
    req = r; full = f; overflow = o;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    #1 compare_all();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr_src", 32'(wr_src), 32'd0);
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    req = '0; full = 1'b0; overflow = 1'b0;
    #1 compare_all();
    rst = 1'b0;
    @(posedge clk);
    model_step();
  endtask

  logic [N-1:0] r;

  initial begin
    rst = 1'b1; req = '0; req_data = '0; full = 1'b0; overflow = 1'b0;
    model_reset();
    do_reset();

    // Single requester: two bursts of MB beats separated by one arbitration cycle
    repeat (10) cycle(4'b0001, 1'b0, 1'b0);
    #2 check_eq("single_wr_count", 32'(wr_count), 32'd8);

    // Round-robin with everyone requesting
    do_reset();
    for (int k = 0; k < 21; k++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      if (k % (MB + 1) == 0) #2 check_eq("rr_owner", 32'(wr_src), 32'((k / (MB + 1)) % N));
    end

    // Stall on full after one beat of owner 2
    do_reset();
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    repeat (3) cycle(4'b0100, 1'b1, 1'b0);
    #2 check_eq("stall_count3", 32'(stall_count), 32'd3);
    check_eq("stall_owner", 32'(wr_src), 32'd2);
    repeat (3) cycle(4'b0100, 1'b0, 1'b0);
    #2 check_eq("stall_wr_count", 32'(wr_count), 32'd4);
    check_eq("stall_done_idle", 32'(busy), 32'd0);

    // Early withdraw of owner 1 while requester 3 waits
    do_reset();
    repeat (3) cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    #2 check_eq("withdraw_idle", 32'(busy), 32'd0);
    cycle(4'b1000, 1'b0, 1'b0);
    #2 check_eq("withdraw_owner3", 32'(wr_src), 32'd3);
    cycle(4'b1000, 1'b1, 1'b0);

    // Reset in the middle of owner 3's burst, then sticky overflow
    do_reset();
    cycle(4'b0000, 1'b0, 1'b1);
    repeat (3) cycle(4'b0000, 1'b0, 1'b0);
    #2 check_eq("ovf_sticky", 32'(ovf_err), 32'd1);
    do_reset();
    check_eq("ovf_cleared", 32'(ovf_err), 32'd0);

    // stall_count saturation
    cycle(4'b0001, 1'b0, 1'b0);
    repeat (65537) cycle(4'b0001, 1'b1, 1'b0);
    #2 check_eq("stall_sat", 32'(stall_count), 32'hFFFF);
    check_eq("sat_no_write", 32'(wr_count), 32'd0);

    // Random traffic with random full and rare overflow
    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i])  r[i] = ($urandom_range(0, 3) != 0);
        else if (r[i]) r[i] = ($urandom_range(0, 19) != 0);
        else           r[i] = ($urandom_range(0, 2) == 0);
      end
      cycle(r, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the team's `async_fifo` among `num_req` requesters in the write clock domain. It grants in round-robin order with a bounded burst per grant and stalls on `full`. It drives `wr_en`/`wdata` directly into the FIFO and keeps write and stall statistics. It sits between the producer blocks and the FIFO write side; the read side is untouched.

## Interface
- `data_width`, 8, width of each requester's data word and of `wdata`.
- `num_req`, 4, number of requesters; power of two, 2..8.
- `max_burst`, 4, maximum beats written per grant; 1..15.
- `src_w`, `$clog2(num_req)`, width of the owner index.
- `wr_clk` input 1: the only clock, FIFO write clock; everything is sampled on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input `num_req`
  - `req[i]` high means requester i has a valid word on its data slice.
  - A requester holds `req` and data stable until granted.
- `req_data` input `num_req*data_width`: packed data; slice i is `[i*data_width +: data_width]`.
- `gnt` output `num_req`: one-hot; `gnt[i]=1` means slice i is written this cycle, and the requester may advance.
- `full` input 1: from the FIFO.
- `overflow` input 1: from the FIFO.
- `wr_en` output 1: to the FIFO.
- `wdata` output `data_width`: to the FIFO.
- `wr_src` output `src_w`: current owner index; valid while `busy`.
- `busy` output 1: high in the BURST state.
- `wr_count` output 16: total beats written; wraps.
- `stall_count` output 16: cycles in BURST with `req[owner]=1` and `full=1`; saturates at 16'hFFFF.
- `ovf_err` output 1: sticky; set on any cycle with `overflow=1`; cleared only by `rst`.

## Operation
- Registered state is `state` (IDLE/BURST), `owner`, `rr_ptr`, `beat_cnt`, `wr_count`, `stall_count` and `ovf_err`.
- **IDLE**
  - If `|req`, `owner` ← first index j scanning `rr_ptr`, `rr_ptr+1`, … mod `num_req` with `req[j]=1`.
  - `beat_cnt` ← 0 and go to BURST.
  - Otherwise stay in IDLE.
- **BURST**, combinational outputs:
  - `wr_en = req[owner] & ~full`
  - `gnt = wr_en << owner`
  - `wdata = req_data` slice `owner`
- **BURST**, per-cycle updates:
  - Each cycle with `wr_en`, `beat_cnt` increments and `wr_count` increments.
  - Each cycle with `req[owner] & full`, `stall_count` increments (saturating); `owner` and `beat_cnt` hold.
- **Leaving BURST** → IDLE, and `rr_ptr` ← `owner+1` mod `num_req`, when either:
  - `wr_en` is high and `beat_cnt == max_burst-1` (the last beat is written this cycle), or
  - `req[owner]=0` (owner withdrew; no write this cycle).
- Outside BURST: `wr_en=0`, `gnt=0`, `wdata` = slice `owner`, which is don't-care to the FIFO.
- A requester other than the owner is never granted, regardless of `full`.
- `full` never ends a burst; the owner keeps the grant until its beats are done or it withdraws. There is no timeout.
- `wr_en` is never high while `full=1`. The arbiter itself never causes an overflow; `ovf_err` flags external misuse.

## Timing
- **Reset** (asynchronous, immediate):
  - `state`=IDLE; `owner`, `rr_ptr`, `beat_cnt`, `wr_count`, `stall_count` = 0; `ovf_err` = 0.
  - Outputs: `wr_en`=0, `gnt`=0, `busy`=0, `wr_src`=0.
  - Reset mid-burst abandons the burst with no further writes.
- **Grant latency:** `req` rising in IDLE in cycle n gives BURST and a possible first write in cycle n+1. There is one arbitration cycle per grant.
- **Throughput:** a requester holding `req` with `full=0` writes `max_burst` consecutive beats, then has 1 IDLE cycle. Peak rate is `max_burst/(max_burst+1)`.
- **Full:** the FIFO samples `wr_en` at the same edge that updates `full`, so a write in the cycle `full` rises is legal. The FIFO must assert `full` combinationally from its write-side state.
- **Simultaneous events:**
  - Last beat plus other requests pending: IDLE for one cycle, then the next index after `owner` wins.
  - `req[owner]` dropping while `full=1`: leave BURST; no stall is counted.
- **Wrap-around:**
  - `rr_ptr` wraps from `num_req-1` to 0.
  - `wr_count` wraps from 16'hFFFF to 0.

## Test plan
- **Reset checks:** assert `rst` for 2 cycles mid-burst → `wr_en=0`, `gnt=0`, `busy=0`, counters 0 the same cycle. Release → IDLE.
- **Single requester:** `req=4'b0001` held for 10 cycles, `full=0`. Expect writes in cycles 1–4, IDLE in 5, writes in 6–9; `wr_count=8`; `wdata` matches slice 0 each granted cycle.
- **Round-robin fairness:** `req=4'b1111` held. Expect owners 0,1,2,3,0 in successive bursts of 4 beats, and `gnt` one-hot matching `wr_src`.
- **Stall on full:** owner 2 in BURST with `beat_cnt=1`; `full=1` for 3 cycles. Expect `wr_en=0`, `owner` held, `stall_count=3`; the burst then completes its remaining 3 beats.
- **Early withdraw:** owner 1 drops `req` after 2 beats with `req[3]=1`. Expect IDLE for 1 cycle, then owner 3 and `rr_ptr=2` during that arbitration.
- **Overflow flag and counter limits:** a 1-cycle `overflow` pulse sets `ovf_err=1`, which stays high until `rst`. `stall_count` forced to 16'hFFFE plus 3 stall cycles reads 16'hFFFF.
